// File: rtl/byte2pix_rgb888_2lane.sv
// rtl/byte2pix_rgb888_2lane.sv - 2-lane byte stream to RGB888 pixel unpacker (optional BYTE2PIX_LEN_CHECK_EN)
module byte2pix_rgb888_2lane #(
    parameter logic [5:0] DT_RGB888 = 6'h24,
    parameter int         WC_W      = 16
) (
    input  logic            clk_byte,
    input  logic            reset_n,
    input  logic            lp_av_en,
    input  logic [5:0]      dt,
    input  logic [WC_W-1:0] wc,
    input  logic            payload_en,
    input  logic [15:0]     payload,
    output logic [23:0]     pix_data,
    output logic            pix_valid,
    output logic            line_done,
    output logic            err_len
);

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_ph;
    logic [1:0]      w_ph_nxt;
    logic [WC_W-1:0] r_rem;
    logic [WC_W-1:0] w_rem_nxt;
    logic [7:0]      r_b0;
    logic [7:0]      r_b1;
    logic [7:0]      w_b0_nxt;
    logic [7:0]      w_b1_nxt;
    logic [23:0]     r_pix_data;
    logic            r_pix_valid;
    logic            r_line_done;
    logic            w_hdr_ok;
    logic            w_take;
    logic            w_two;
    logic            w_emit;
    logic            w_end;
    logic [23:0]     w_pix;

    // A header is accepted only for the RGB888 data type with a non-empty payload.
    assign w_hdr_ok = lp_av_en && (dt == DT_RGB888) && (wc != '0);
    // Header strobe has priority, so a payload word in the same cycle is dropped.
    assign w_take   = !lp_av_en && payload_en && (r_state == ST_ACTIVE);
    // Two bytes are consumed unless only one byte of the line remains.
    assign w_two    = |r_rem[WC_W-1:1];

    // Next-state, gearbox and pixel assembly.
    always_comb begin
        w_state_nxt = r_state;
        w_ph_nxt    = r_ph;
        w_rem_nxt   = r_rem;
        w_b0_nxt    = r_b0;
        w_b1_nxt    = r_b1;
        w_emit      = 1'b0;
        w_end       = 1'b0;
        w_pix       = '0;
        if (lp_av_en) begin
            w_ph_nxt = 2'd0;
            if (w_hdr_ok) begin
                w_state_nxt = ST_ACTIVE;
                w_rem_nxt   = wc;
            end else begin
                w_state_nxt = ST_IDLE;
                w_rem_nxt   = '0;
            end
        end else if (w_take) begin
            w_rem_nxt = r_rem - {{(WC_W-2){1'b0}}, w_two, !w_two};
            case (r_ph)
                2'd0: begin
                    w_b0_nxt = payload[7:0];
                    w_b1_nxt = payload[15:8];
                    w_ph_nxt = 2'd1;
                end
                2'd1: begin
                    w_emit   = 1'b1;
                    w_pix    = {payload[7:0], r_b1, r_b0};
                    w_b0_nxt = payload[15:8];
                    w_ph_nxt = 2'd2;
                end
                default: begin
                    w_emit   = w_two;
                    w_pix    = {payload[15:8], payload[7:0], r_b0};
                    w_ph_nxt = 2'd0;
                end
            endcase
            if (w_rem_nxt == '0) begin
                w_end       = 1'b1;
                w_state_nxt = ST_IDLE;
                w_ph_nxt    = 2'd0;
            end
        end
    end

    // FSM state, gearbox phase and remaining byte count.
    always_ff @(posedge clk_byte) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_ph    <= 2'd0;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ph    <= w_ph_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    // Stored partial bytes and registered pixel/line outputs.
    always_ff @(posedge clk_byte) begin
        if (!reset_n) begin
            r_b0        <= '0;
            r_b1        <= '0;
            r_pix_data  <= '0;
            r_pix_valid <= 1'b0;
            r_line_done <= 1'b0;
        end else begin
            r_b0        <= w_b0_nxt;
            r_b1        <= w_b1_nxt;
            r_pix_valid <= w_emit;
            r_line_done <= w_end;
            if (w_emit) begin
                r_pix_data <= w_pix;
            end
        end
    end

    assign pix_data  = r_pix_data;
    assign pix_valid = r_pix_valid;
    assign line_done = r_line_done;

`ifdef BYTE2PIX_LEN_CHECK_EN
    logic w_leftover;
    logic r_err_len;

    // Bytes are left over unless the final word exactly completes a pixel.
    assign w_leftover = !(((r_ph == 2'd1) && !w_two) || ((r_ph == 2'd2) && w_two));

    // Sticky length error, raised alongside line_done of a line with leftover bytes.
    always_ff @(posedge clk_byte) begin
        if (!reset_n) begin
            r_err_len <= 1'b0;
        end else if (w_end && w_leftover) begin
            r_err_len <= 1'b1;
        end
    end

    assign err_len = r_err_len;
`else
    assign err_len = 1'b0;
`endif

endmodule

// File: tb/tb_byte2pix_rgb888_2lane.sv
// tb/tb_byte2pix_rgb888_2lane.sv - directed scoreboard bench for byte2pix_rgb888_2lane
module tb_byte2pix_rgb888_2lane;

`ifdef BYTE2PIX_LEN_CHECK_EN
    localparam bit LEN_CHK = 1'b1;
`else
    localparam bit LEN_CHK = 1'b0;
`endif

    logic        clk_byte;
    logic        reset_n;
    logic        lp_av_en;
    logic [5:0]  dt;
    logic [15:0] wc;
    logic        payload_en;
    logic [15:0] payload;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        line_done;
    logic        err_len;

    typedef struct packed {
        logic        v;
        logic [23:0] p;
        logic        d;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic exp_err = 1'b0;

    byte2pix_rgb888_2lane dut (
        .clk_byte   (clk_byte),
        .reset_n    (reset_n),
        .lp_av_en   (lp_av_en),
        .dt         (dt),
        .wc         (wc),
        .payload_en (payload_en),
        .payload    (payload),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .line_done  (line_done),
        .err_len    (err_len)
    );

    initial clk_byte = 1'b0;
    always #5 clk_byte = ~clk_byte;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed empty scoreboard expected entry", tag);
        end else begin
            e = q.pop_front();
            chk({tag, ".valid"}, {23'd0, pix_valid}, {23'd0, e.v});
            if (e.v) chk({tag, ".pix"}, pix_data, e.p);
            chk({tag, ".done"}, {23'd0, line_done}, {23'd0, e.d});
            chk({tag, ".err"}, {23'd0, err_len}, {23'd0, exp_err});
        end
    endtask

    task automatic drive(input logic lp, input logic [5:0] d, input logic [15:0] w,
                         input logic pen, input logic [15:0] pl,
                         input logic ev, input logic [23:0] ep, input logic ed,
                         input logic eset, input string tag);
        exp_t e;
        lp_av_en   = lp;
        dt         = d;
        wc         = w;
        payload_en = pen;
        payload    = pl;
        e.v = ev;
        e.p = ep;
        e.d = ed;
        q.push_back(e);
        if (eset && LEN_CHK) exp_err = 1'b1;
        @(posedge clk_byte);
        #1;
        pop_check(tag);
        lp_av_en   = 1'b0;
        payload_en = 1'b0;
    endtask

    task automatic hdr(input logic [5:0] d, input logic [15:0] w, input string tag);
        drive(1'b1, d, w, 1'b0, 16'h0, 1'b0, 24'h0, 1'b0, 1'b0, tag);
    endtask

    task automatic wd(input logic [15:0] pl, input logic ev, input logic [23:0] ep,
                      input logic ed, input logic eset, input string tag);
        drive(1'b0, 6'h0, 16'h0, 1'b1, pl, ev, ep, ed, eset, tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++)
            drive(1'b0, 6'h0, 16'h0, 1'b0, 16'h0, 1'b0, 24'h0, 1'b0, 1'b0, tag);
    endtask

    task automatic rst(input logic pen, input logic [15:0] pl, input string tag);
        exp_t e;
        reset_n    = 1'b0;
        lp_av_en   = 1'b0;
        payload_en = pen;
        payload    = pl;
        exp_err    = 1'b0;
        e = '0;
        q.push_back(e);
        @(posedge clk_byte);
        #1;
        pop_check(tag);
        chk({tag, ".pixzero"}, pix_data, 24'h0);
        reset_n    = 1'b1;
        payload_en = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        lp_av_en   = 1'b0;
        dt         = 6'h0;
        wc         = 16'h0;
        payload_en = 1'b0;
        payload    = 16'h0;

        rst(1'b0, 16'h0, "reset0");
        rst(1'b0, 16'h0, "reset1");

        // basic 6-byte line, back-to-back
        hdr(6'h24, 16'd6, "b2b.hdr");
        wd(16'h0201, 1'b0, 24'h0,      1'b0, 1'b0, "b2b.w1");
        wd(16'h0403, 1'b1, 24'h030201, 1'b0, 1'b0, "b2b.w2");
        wd(16'h0605, 1'b1, 24'h060504, 1'b1, 1'b0, "b2b.w3");
        idle(1, "b2b.after");

        // same line with two idle cycles between words
        hdr(6'h24, 16'd6, "gap.hdr");
        wd(16'h0201, 1'b0, 24'h0,      1'b0, 1'b0, "gap.w1");
        idle(2, "gap.i1");
        wd(16'h0403, 1'b1, 24'h030201, 1'b0, 1'b0, "gap.w2");
        idle(2, "gap.i2");
        wd(16'h0605, 1'b1, 24'h060504, 1'b1, 1'b0, "gap.w3");
        idle(1, "gap.after");

        // wc=7: two pixels, byte 7 discarded, lane1 of last word ignored
        hdr(6'h24, 16'd7, "wc7.hdr");
        wd(16'h0201, 1'b0, 24'h0,      1'b0, 1'b0, "wc7.w1");
        wd(16'h0403, 1'b1, 24'h030201, 1'b0, 1'b0, "wc7.w2");
        wd(16'h0605, 1'b1, 24'h060504, 1'b0, 1'b0, "wc7.w3");
        wd(16'hAA07, 1'b0, 24'h0,      1'b1, 1'b1, "wc7.w4");
        idle(1, "wc7.after");

        // wrong data type is rejected, payload ignored
        hdr(6'h2B, 16'd6, "dt.hdr");
        wd(16'h0201, 1'b0, 24'h0, 1'b0, 1'b0, "dt.w1");
        wd(16'h0403, 1'b0, 24'h0, 1'b0, 1'b0, "dt.w2");
        wd(16'h0605, 1'b0, 24'h0, 1'b0, 1'b0, "dt.w3");

        // restart mid-line with a new accepted header
        hdr(6'h24, 16'd6, "rst6.hdr");
        wd(16'h0201, 1'b0, 24'h0, 1'b0, 1'b0, "rst6.w1");
        hdr(6'h24, 16'd3, "rst3.hdr");
        wd(16'h1211, 1'b0, 24'h0,      1'b0, 1'b0, "rst3.w1");
        wd(16'h1413, 1'b1, 24'h131211, 1'b1, 1'b0, "rst3.w2");
        idle(1, "rst3.after");

        // header and payload in the same cycle: payload dropped
        drive(1'b1, 6'h24, 16'd3, 1'b1, 16'h9999, 1'b0, 24'h0, 1'b0, 1'b0, "coll.hdr");
        wd(16'h2221, 1'b0, 24'h0,      1'b0, 1'b0, "coll.w1");
        wd(16'h2423, 1'b1, 24'h232221, 1'b1, 1'b0, "coll.w2");

        // wc=0 header is rejected
        hdr(6'h24, 16'd0, "wc0.hdr");
        wd(16'h0201, 1'b0, 24'h0, 1'b0, 1'b0, "wc0.w1");
        wd(16'h0403, 1'b0, 24'h0, 1'b0, 1'b0, "wc0.w2");

        // rejected header mid-line aborts to idle
        hdr(6'h24, 16'd6, "abt.hdr");
        wd(16'h0201, 1'b0, 24'h0, 1'b0, 1'b0, "abt.w1");
        hdr(6'h2B, 16'd6, "abt.bad");
        wd(16'h0403, 1'b0, 24'h0, 1'b0, 1'b0, "abt.w2");
        wd(16'h0605, 1'b0, 24'h0, 1'b0, 1'b0, "abt.w3");

        // reset mid-line discards the line
        hdr(6'h24, 16'd6, "mrst.hdr");
        wd(16'h0201, 1'b0, 24'h0,      1'b0, 1'b0, "mrst.w1");
        wd(16'h0403, 1'b1, 24'h030201, 1'b0, 1'b0, "mrst.w2");
        rst(1'b1, 16'h0605, "mrst.reset");
        wd(16'h0605, 1'b0, 24'h0, 1'b0, 1'b0, "mrst.w3");
        idle(1, "mrst.after");

        // single-byte line: no pixel, line_done, leftover error
        hdr(6'h24, 16'd1, "wc1.hdr");
        wd(16'hBB55, 1'b0, 24'h0, 1'b1, 1'b1, "wc1.w1");
        idle(1, "wc1.after");

        // maximum word count does not wrap
        hdr(6'h24, 16'hFFFF, "max.hdr");
        wd(16'h0201, 1'b0, 24'h0,      1'b0, 1'b0, "max.w1");
        wd(16'h0403, 1'b1, 24'h030201, 1'b0, 1'b0, "max.w2");
        wd(16'h0605, 1'b1, 24'h060504, 1'b0, 1'b0, "max.w3");
        hdr(6'h24, 16'd3, "max.restart");
        wd(16'h3231, 1'b0, 24'h0,      1'b0, 1'b0, "max.w4");
        wd(16'h3433, 1'b1, 24'h333231, 1'b1, 1'b0, "max.w5");
        idle(2, "final");

        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d entries expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
